// File: rtl/btn_event_arbiter_pkg.sv
// Shared encodings for the button event arbiter: release-detector states,
// offer FSM states and the default channel count.
package btn_event_arbiter_pkg;

  localparam int N_REQ_DEFAULT = 4;

  typedef logic [0:0] det_state_t;
  localparam det_state_t DET_IDLE    = 1'b0;
  localparam det_state_t DET_PRESSED = 1'b1;

  typedef logic [0:0] ofr_state_t;
  localparam ofr_state_t OFR_SCAN  = 1'b0;
  localparam ofr_state_t OFR_OFFER = 1'b1;

endpackage

// File: rtl/btn_release_detect.sv
// Per-channel release detector: a low level arms it, the following high level
// produces a one-cycle registered pulse.
module btn_release_detect
  import btn_event_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  det_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DET_IDLE;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        DET_IDLE: begin
          if (!btn) state <= DET_PRESSED;
        end
        default: begin
          if (btn) begin
            state <= DET_IDLE;
            pulse <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Collects button release events per channel and offers them one at a time
// to a consumer using round-robin selection with a valid/ready handshake.
module btn_event_arbiter
  import btn_event_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] btn_in,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] ovf
);

  logic [N_REQ-1:0] pulse;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] ovf_set;
  logic             accept;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] last_grant;
  ofr_state_t       state;

  for (genvar i = 0; i < N_REQ; i++) begin : g_det
    btn_release_detect u_det (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_in[i]),
      .pulse (pulse[i])
    );
  end

  assign accept = evt_valid & evt_ready;

  // A pulse landing on the channel being accepted re-arms it instead of overflowing.
  always_comb begin
    clr = '0;
    if (accept) clr[evt_idx] = 1'b1;
    ovf_set = pulse & pending & ~clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= (pending & ~clr) | pulse;
      ovf     <= (ovf_clr ? '0 : ovf) | ovf_set;
    end
  end

  always_comb begin
    int cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_grant) + k) % N_REQ;
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  // last_grant starts at the top channel so channel 0 wins the first search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFR_SCAN;
      evt_valid  <= 1'b0;
      evt_idx    <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
    end else begin
      case (state)
        OFR_SCAN: begin
          if (sel_found) begin
            evt_idx   <= sel_idx;
            evt_valid <= 1'b1;
            state     <= OFR_OFFER;
          end
        end
        default: begin
          if (evt_ready) begin
            last_grant <= evt_idx;
            evt_valid  <= 1'b0;
            state      <= OFR_SCAN;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/btn_event_arbiter.md
BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of button channels, legal range 2..8.
REQ-002 The block SHALL have parameter IDX_W, default 2: evt_idx width, equal to clog2(N_REQ).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 The block SHALL have port btn_in  input  N_REQ  raw button levels, synchronous to clk, low = pressed.
REQ-006 The block SHALL have port evt_ready  input  1  consumer accepts the offered event.
REQ-007 The block SHALL have port ovf_clr  input  1  single-cycle clear of all overflow flags.
REQ-008 The block SHALL have port evt_valid  output  1  an event is offered on evt_idx.
REQ-009 The block SHALL have port evt_idx  output  IDX_W  channel number of the offered event.
REQ-010 The block SHALL have port pending  output  N_REQ  per-channel event-waiting flags.
REQ-011 The block SHALL have port ovf  output  N_REQ  sticky per-channel dropped-event flags.

Function
REQ-012 Each channel detector SHALL have two states: IDLE and PRESSED.
REQ-013 IDLE SHALL go to PRESSED when btn_in[i]=0; PRESSED SHALL return to IDLE when btn_in[i]=1, asserting the channel pulse for exactly one cycle, registered one cycle after the sampled high.
REQ-014 A detector pulse SHALL set pending[i] on the next edge.
REQ-015 A pulse on a channel whose pending bit is already set and is not being accepted that cycle SHALL set ovf[i]; the event is dropped.
REQ-016 A pulse in the same cycle as acceptance of that channel SHALL leave pending[i]=1 and SHALL NOT set ovf[i].
REQ-017 The offer FSM SHALL have two states: SCAN and OFFER.
REQ-018 In SCAN, if any pending bit is set, the FSM SHALL select a channel round-robin, searching from last_grant+1 with wrap-around, register it to evt_idx, set evt_valid=1 and go to OFFER; otherwise it SHALL stay in SCAN with evt_valid=0.
REQ-019 In OFFER, evt_valid and evt_idx SHALL be held stable until evt_valid&evt_ready.
REQ-020 On acceptance, the FSM SHALL clear pending[evt_idx] (subject to REQ-016), set last_grant=evt_idx, drive evt_valid=0 and go to SCAN.
REQ-021 Maximum throughput SHALL be one event per 2 cycles; latency from detector pulse to evt_valid SHALL be 2 cycles when SCAN is idle.
REQ-022 evt_ready SHALL be ignored while evt_valid=0.
REQ-023 ovf_clr=1 SHALL clear all ovf bits; a same-cycle new overflow on a channel SHALL win, leaving that bit set.
REQ-024 pending SHALL never clear without acceptance; ovf SHALL never clear without ovf_clr or reset.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: detectors to IDLE, pulses=0, pending=0, ovf=0, evt_valid=0, evt_idx=0, FSM to SCAN, last_grant=N_REQ-1 (channel 0 served first).
REQ-026 Reset asserted during OFFER SHALL drop the offered event with no acceptance recorded.
REQ-027 After rst_n deasserts, a button held low SHALL be treated as a fresh press, so its release generates an event.

Structure
REQ-028 A shared package/include SHALL hold the detector state encodings (IDLE/PRESSED), the offer FSM encodings (SCAN/OFFER) and the N_REQ default.
REQ-029 The block SHALL define one sub-module, btn_release_detect (clk, rst_n, btn, pulse), instantiated N_REQ times.
REQ-030 Arbitration, pending/ovf registers and the offer FSM SHALL reside in btn_event_arbiter.

Verification
REQ-031 Directed test: N_REQ=4, evt_ready=1; btn_in[2] goes 1->0->1 -> exactly one event, evt_idx=2, evt_valid high 1 cycle, 2 cycles after the pulse; pending returns to 0000.
REQ-032 Directed test: channels 0,1,3 released in the same cycle, evt_ready=1 -> events in order 0,1,3, each 2 cycles apart.
REQ-033 Directed test: evt_ready=0 for 10 cycles while evt_idx=1 is offered -> evt_valid/evt_idx stay stable; a second release on ch1 sets ovf=0010; ovf_clr pulse -> ovf=0000.
REQ-034 Directed test: ch0 released in the same cycle its offer is accepted -> ovf[0]=0 and ch0 is offered again after the remaining pending channels are served.
REQ-035 Directed test: rst_n pulsed low during OFFER -> all outputs 0 asynchronously; the next ch3 release yields evt_idx=3.
REQ-036 Directed test: ch0 and ch1 each released once per cycle pair continuously, evt_ready=1 -> grants alternate 0,1,0,1 with no starvation.
